ge_compare_scheduler: RTL and testbench
=======================================

// Module: ge_compare_scheduler
// PURPOSE
//  Shares one pipelined FloPoCo FP subtractor (FPSub_11_12_F400_uid2) among NREQ
//  slab-test requesters of the Ray-AABB core, using a round-robin arbiter.
//  Each granted request computes A-B. The result is decoded to a >= flag and returned
//  to the originating requester, tagged by ID. One issue per cycle; fully pipelined.
// PARAMETERS
//  WIDTH    25  MSB index of FloPoCo operand (operand = WIDTH+1 bits: exc[2],sign,exp,frac)
//  NREQ     4   number of requesters (2..8)
//  IDW      2   tag width, clog2(NREQ)
//  SUB_LAT  2   pipeline latency of FPSub in cycles (X/Y sampled -> R valid)
// PORTS
//  clk         in   1              clock, all logic on posedge
//  rst         in   1              synchronous, active-low reset
//  req_valid   in   NREQ           requester i has an operand pair
//  req_ready   out  NREQ           one-hot grant; handshake when valid&ready
//  req_a       in   NREQ*(WIDTH+1) operand A of requester i at [i*(WIDTH+1)+:WIDTH+1]
//  req_b       in   NREQ*(WIDTH+1) operand B, same packing
//  resp_valid  out  NREQ           one-cycle pulse to originating requester
//  resp_ge     out  1              A>=B result, qualified by resp_valid
//  resp_nan    out  1              result unordered (R exc=11), qualified by resp_valid
//  busy        out  1              any operation in flight (issue..response)
// BEHAVIOUR
//  Reset (rst==0 at posedge): req_ready=0, resp_valid=0, resp_ge=0, resp_nan=0,
//   busy=0, rr pointer=0, all in-flight tags invalidated. In-flight operations are
//   dropped; no response ever appears for them after reset is released.
//  Arbitration: combinational req_ready = one-hot round-robin pick among req_valid.
//   Search starts at ptr. After a handshake with requester g, ptr <= (g+1) mod NREQ.
//   With no request, ptr holds. req_ready is never asserted to a non-valid requester.
//   req_ready is forced to 0 while rst==0.
//  Issue stage (S0): on handshake at cycle t, register A,B -> X,Y and tag {1,g}.
//  Subtract: X,Y feed FPSub at t+1. R is valid at t+1+SUB_LAT.
//   Tag travels in a SUB_LAT-deep valid/id shift register aligned with R.
//  Decode stage (registered), on R: exc=R[WIDTH:WIDTH-1], sign=R[WIDTH-2]:
//   exc=00 (zero)         -> ge=1 nan=0
//   exc=01/10, sign=0     -> ge=1 nan=0   (positive normal / +inf)
//   exc=01/10, sign=1     -> ge=0 nan=0
//   exc=11 (NaN)          -> ge=0 nan=1
//  Response: resp_valid[id] pulses at cycle t+SUB_LAT+2, exactly 1 cycle.
//   Total latency is fixed at SUB_LAT+2 regardless of contention.
//   At most one resp_valid bit is high per cycle.
//   resp_ge/resp_nan are 0 when no resp_valid. Responses return in issue order.
//  No response backpressure: requesters must accept resp_valid pulses.
//  Back-to-back issue every cycle: throughput 1 op/cycle; no bubbles inserted.
//  busy = |{S0 tag valid, shift-reg valids, decode valid}.
//  Simultaneous events: new issue and response in the same cycle are independent.
//   The same requester may have multiple ops in flight.
//  Width rules: operands are passed unmodified; no internal rounding or normalisation.
// TESTING
//  1. Single req0: A=+3.0, B=+2.0 -> resp_valid=0001 at t+SUB_LAT+2, ge=1, nan=0.
//  2. A=+1.0, B=+1.0 (R zero) -> ge=1. A=-5.0, B=+1.0 -> ge=0. A=+inf, B=+1.0 -> ge=1.
//  3. A=NaN(exc=11), B=+1.0 -> resp ge=0, nan=1.
//  4. All 4 req_valid high for 8 cycles -> grants 0,1,2,3,0,1,2,3.
//     Responses arrive in the same order, one per cycle; busy stays 1.
//  5. Only req2 and req0 valid, ptr=1 -> grant req2 first, then req0. Idle cycles keep ptr.
//  6. Issue 3 ops, assert rst=0 one cycle mid-flight -> all outputs 0 next cycle.
//     No resp_valid after release; next issue gets grant to req0 first.

Source files
------------

// File: rtl/ge_compare_scheduler.sv
// Round-robin scheduler sharing one pipelined FP subtractor among NREQ slab-test
// requesters; each A-B result is reduced to a >= / unordered flag and routed back by tag.
module ge_compare_scheduler #(
  parameter int WIDTH   = 25,
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int SUB_LAT = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NREQ-1:0]             req_valid,
  output logic [NREQ-1:0]             req_ready,
  input  logic [NREQ*(WIDTH+1)-1:0]   req_a,
  input  logic [NREQ*(WIDTH+1)-1:0]   req_b,
  output logic [NREQ-1:0]             resp_valid,
  output logic                        resp_ge,
  output logic                        resp_nan,
  output logic                        busy
);

  localparam int OPW = WIDTH + 1;
  localparam int MW  = WIDTH - 2;

  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [IDW-1:0]  gid;
  logic [NREQ-1:0] grant;
  logic            handshake;

  logic [OPW-1:0]  x_q, y_q;
  logic            s0_vld_q;
  logic [IDW-1:0]  s0_id_q;
  logic [SUB_LAT-1:0] tag_vld_q;
  logic [IDW-1:0]  tag_id_q [SUB_LAT];

  // Subtractor result carries {exc[1:0], sign}: the only fields the decode consumes.
  logic [2:0]      r_d;
  logic [2:0]      r_q [SUB_LAT];

  logic [NREQ-1:0] resp_valid_q, resp_valid_d;
  logic            resp_ge_q, resp_ge_d;
  logic            resp_nan_q, resp_nan_d;

  always_comb begin
    logic hit;
    int   idx;
    grant = '0;
    gid   = '0;
    hit   = 1'b0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (!hit && req_valid[idx]) begin
        hit        = 1'b1;
        grant[idx] = 1'b1;
        gid        = IDW'(idx);
      end
    end
  end

  assign req_ready = rst ? grant : '0;
  assign handshake = |req_ready;
  assign ptr_d     = (int'(gid) == NREQ - 1) ? '0 : gid + IDW'(1);

  // Sign/exception of X - Y, evaluated as X + (-Y) with FloPoCo special-value rules.
  always_comb begin
    logic [1:0]    ea, eb;
    logic          sa, sb, sbn;
    logic [MW-1:0] ma, mb;
    ea  = x_q[WIDTH -: 2];
    eb  = y_q[WIDTH -: 2];
    sa  = x_q[WIDTH-2];
    sb  = y_q[WIDTH-2];
    ma  = x_q[MW-1:0];
    mb  = y_q[MW-1:0];
    sbn = ~sb;
    r_d = {2'b01, 1'b0};
    if (ea == 2'b11 || eb == 2'b11)        r_d = {2'b11, 1'b0};
    else if (ea == 2'b10 && eb == 2'b10)   r_d = (sa == sbn) ? {2'b10, sa} : {2'b11, 1'b0};
    else if (ea == 2'b10)                  r_d = {2'b10, sa};
    else if (eb == 2'b10)                  r_d = {2'b10, sbn};
    else if (ea == 2'b00 && eb == 2'b00)   r_d = {2'b00, 1'b0};
    else if (ea == 2'b00)                  r_d = {2'b01, sbn};
    else if (eb == 2'b00)                  r_d = {2'b01, sa};
    else if (sa != sb)                     r_d = {2'b01, sa};
    else if (ma == mb)                     r_d = {2'b00, 1'b0};
    else if (ma > mb)                      r_d = {2'b01, sa};
    else                                   r_d = {2'b01, ~sa};
  end

  always_ff @(posedge clk) begin
    if (handshake) begin
      x_q <= req_a[gid*OPW +: OPW];
      y_q <= req_b[gid*OPW +: OPW];
    end
    s0_id_q     <= gid;
    r_q[0]      <= r_d;
    tag_id_q[0] <= s0_id_q;
    for (int i = 1; i < SUB_LAT; i++) begin
      r_q[i]      <= r_q[i-1];
      tag_id_q[i] <= tag_id_q[i-1];
    end
  end

  always_comb begin
    logic [1:0] exc;
    logic       sgn;
    exc          = r_q[SUB_LAT-1][2:1];
    sgn          = r_q[SUB_LAT-1][0];
    resp_valid_d = '0;
    resp_ge_d    = 1'b0;
    resp_nan_d   = 1'b0;
    if (tag_vld_q[SUB_LAT-1]) begin
      resp_valid_d = NREQ'(1) << tag_id_q[SUB_LAT-1];
      resp_ge_d    = (exc == 2'b00) || (exc != 2'b11 && !sgn);
      resp_nan_d   = (exc == 2'b11);
    end
  end

  // Only valid bits are reset; data/tag payloads are qualified by them.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q        <= '0;
      s0_vld_q     <= 1'b0;
      tag_vld_q    <= '0;
      resp_valid_q <= '0;
      resp_ge_q    <= 1'b0;
      resp_nan_q   <= 1'b0;
    end else begin
      if (handshake) ptr_q <= ptr_d;
      s0_vld_q     <= handshake;
      tag_vld_q[0] <= s0_vld_q;
      for (int i = 1; i < SUB_LAT; i++) tag_vld_q[i] <= tag_vld_q[i-1];
      resp_valid_q <= resp_valid_d;
      resp_ge_q    <= resp_ge_d;
      resp_nan_q   <= resp_nan_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_ge    = resp_ge_q;
  assign resp_nan   = resp_nan_q;
  assign busy       = s0_vld_q | (|tag_vld_q) | (|resp_valid_q);

endmodule

// File: tb/tb_ge_compare_scheduler.sv
// Directed bench for ge_compare_scheduler: decode cases, round-robin order,
// pointer behaviour, fixed latency and mid-flight reset.
module tb_ge_compare_scheduler;

  localparam int W  = 25;
  localparam int NR = 4;
  localparam int OW = W + 1;

  localparam logic [25:0] P3   = {2'b01, 1'b0, 11'h400, 12'h800};
  localparam logic [25:0] P2   = {2'b01, 1'b0, 11'h400, 12'h000};
  localparam logic [25:0] P1   = {2'b01, 1'b0, 11'h3FF, 12'h000};
  localparam logic [25:0] M1   = {2'b01, 1'b1, 11'h3FF, 12'h000};
  localparam logic [25:0] M3   = {2'b01, 1'b1, 11'h400, 12'h800};
  localparam logic [25:0] M5   = {2'b01, 1'b1, 11'h401, 12'h400};
  localparam logic [25:0] PINF = {2'b10, 1'b0, 11'h000, 12'h000};
  localparam logic [25:0] QNAN = {2'b11, 1'b0, 11'h000, 12'h000};

  logic              clk;
  logic              rst;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*OW-1:0]  req_a;
  logic [NR*OW-1:0]  req_b;
  logic [NR-1:0]     resp_valid;
  logic              resp_ge;
  logic              resp_nan;
  logic              busy;

  int tests;
  int fails;

  ge_compare_scheduler #(.WIDTH(W), .NREQ(NR), .IDW(2), .SUB_LAT(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ge(resp_ge), .resp_nan(resp_nan),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic set_op(input int id, input logic [25:0] a, input logic [25:0] b);
    req_a[id*OW +: OW] = a;
    req_b[id*OW +: OW] = b;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req_valid = 4'hF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++; if (req_ready !== 4'h0) begin fails++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    tests++; if (resp_valid !== 4'h0) begin fails++; $display("FAIL reset_resp_valid: got %b want 0000", resp_valid); end
    tests++; if (resp_ge !== 1'b0 || resp_nan !== 1'b0) begin fails++; $display("FAIL reset_flags: ge=%b nan=%b want 0 0", resp_ge, resp_nan); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    $display("[TB] reset checked");
    @(posedge clk); #1;
    rst = 1'b1;
    req_valid = '0;
  endtask

  task automatic test_single_op(input string name, input int id, input logic [25:0] a,
                                input logic [25:0] b, input logic eg, input logic en);
    logic [3:0] oh;
    logic [3:0] ev;
    oh = 4'b0001 << id;
    @(posedge clk); #1;
    set_op(id, a, b);
    req_valid = oh;
    @(negedge clk);
    tests++; if (req_ready !== oh) begin fails++; $display("FAIL %s_ready: got %b want %b", name, req_ready, oh); end
    @(posedge clk); #1;
    req_valid = '0;
    for (int cyc = 1; cyc <= 5; cyc++) begin
      @(negedge clk);
      ev = (cyc == 4) ? oh : 4'h0;
      tests++; if (resp_valid !== ev) begin fails++; $display("FAIL %s_resp_valid c%0d: got %b want %b", name, cyc, resp_valid, ev); end
      tests++;
      if (cyc == 4) begin
        if (resp_ge !== eg || resp_nan !== en) begin fails++; $display("FAIL %s_result: ge=%b nan=%b want ge=%b nan=%b", name, resp_ge, resp_nan, eg, en); end
      end else begin
        if (resp_ge !== 1'b0 || resp_nan !== 1'b0) begin fails++; $display("FAIL %s_unqualified c%0d: ge=%b nan=%b want 0 0", name, cyc, resp_ge, resp_nan); end
      end
      tests++; if (busy !== (cyc <= 4)) begin fails++; $display("FAIL %s_busy c%0d: got %b want %b", name, cyc, busy, (cyc <= 4)); end
    end
    $display("[TB] op %s id=%0d expect ge=%b nan=%b", name, id, eg, en);
  endtask

  task automatic test_round_robin();
    logic [3:0] er, ev;
    logic       ge_tab [4];
    logic       nan_tab [4];
    ge_tab  = '{1'b1, 1'b0, 1'b0, 1'b1};
    nan_tab = '{1'b0, 1'b0, 1'b1, 1'b0};
    set_op(0, P3, P2);
    set_op(1, M5, P1);
    set_op(2, QNAN, P1);
    set_op(3, P1, P1);
    for (int c = 0; c <= 12; c++) begin
      @(posedge clk); #1;
      req_valid = (c < 8) ? 4'hF : 4'h0;
      @(negedge clk);
      er = (c < 8) ? (4'b0001 << (c % 4)) : 4'h0;
      ev = (c >= 4 && c < 12) ? (4'b0001 << ((c - 4) % 4)) : 4'h0;
      tests++; if (req_ready !== er) begin fails++; $display("FAIL rr_grant c%0d: got %b want %b", c, req_ready, er); end
      tests++; if (resp_valid !== ev) begin fails++; $display("FAIL rr_resp c%0d: got %b want %b", c, resp_valid, ev); end
      if (c >= 4 && c < 12) begin
        tests++;
        if (resp_ge !== ge_tab[(c-4)%4] || resp_nan !== nan_tab[(c-4)%4]) begin
          fails++; $display("FAIL rr_result c%0d: ge=%b nan=%b want ge=%b nan=%b", c, resp_ge, resp_nan, ge_tab[(c-4)%4], nan_tab[(c-4)%4]);
        end
      end
      tests++; if (busy !== (c >= 1 && c <= 11)) begin fails++; $display("FAIL rr_busy c%0d: got %b want %b", c, busy, (c >= 1 && c <= 11)); end
      $display("[TB] rr cycle %0d ready=%b resp=%b", c, req_ready, resp_valid);
    end
  endtask

  task automatic test_priority();
    logic [3:0] vt [10];
    logic [3:0] rt [10];
    logic [3:0] pt [10];
    logic       gt [10];
    vt = '{4'h1, 4'h0, 4'h0, 4'h5, 4'h5, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    rt = '{4'h1, 4'h0, 4'h0, 4'h4, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    pt = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h4, 4'h1, 4'h0};
    gt = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    set_op(0, P1, P2);
    set_op(2, P2, P1);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      req_valid = vt[c];
      @(negedge clk);
      tests++; if (req_ready !== rt[c]) begin fails++; $display("FAIL prio_grant c%0d: got %b want %b", c, req_ready, rt[c]); end
      tests++; if (resp_valid !== pt[c]) begin fails++; $display("FAIL prio_resp c%0d: got %b want %b", c, resp_valid, pt[c]); end
      tests++; if (resp_ge !== gt[c]) begin fails++; $display("FAIL prio_ge c%0d: got %b want %b", c, resp_ge, gt[c]); end
      $display("[TB] prio cycle %0d ready=%b resp=%b", c, req_ready, resp_valid);
    end
  endtask

  task automatic test_reset_midflight();
    logic [3:0] rt, pt;
    logic       bt;
    for (int c = 0; c <= 13; c++) begin
      @(posedge clk); #1;
      rst       = (c == 3) ? 1'b0 : 1'b1;
      req_valid = (c <= 3) ? 4'h7 : ((c == 8) ? 4'hF : 4'h0);
      @(negedge clk);
      case (c)
        0:       rt = 4'h2;
        1:       rt = 4'h4;
        2:       rt = 4'h1;
        8:       rt = 4'h1;
        default: rt = 4'h0;
      endcase
      pt = (c == 12) ? 4'h1 : 4'h0;
      bt = (c >= 1 && c <= 3) || (c >= 9 && c <= 12);
      tests++; if (req_ready !== rt) begin fails++; $display("FAIL mrst_grant c%0d: got %b want %b", c, req_ready, rt); end
      tests++; if (resp_valid !== pt) begin fails++; $display("FAIL mrst_resp c%0d: got %b want %b", c, resp_valid, pt); end
      tests++; if (resp_ge !== 1'b0 || resp_nan !== 1'b0) begin fails++; $display("FAIL mrst_flags c%0d: ge=%b nan=%b want 0 0", c, resp_ge, resp_nan); end
      tests++; if (busy !== bt) begin fails++; $display("FAIL mrst_busy c%0d: got %b want %b", c, busy, bt); end
      $display("[TB] mrst cycle %0d ready=%b resp=%b busy=%b", c, req_ready, resp_valid, busy);
    end
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    rst       = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    test_reset();
    test_round_robin();
    test_single_op("p3_minus_p2",   0, P3,   P2, 1'b1, 1'b0);
    test_single_op("p1_minus_p1",   1, P1,   P1, 1'b1, 1'b0);
    test_single_op("m5_minus_p1",   2, M5,   P1, 1'b0, 1'b0);
    test_single_op("pinf_minus_p1", 3, PINF, P1, 1'b1, 1'b0);
    test_single_op("nan_minus_p1",  0, QNAN, P1, 1'b0, 1'b1);
    test_single_op("p1_minus_p3",   1, P1,   P3, 1'b0, 1'b0);
    test_single_op("m1_minus_m3",   2, M1,   M3, 1'b1, 1'b0);
    test_single_op("pinf_minus_pinf", 3, PINF, PINF, 1'b0, 1'b1);
    test_priority();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
